// File: rtl/ulss_pck_store_pkg.sv
// ulss_pck_store_pkg: shared word format, FSM states and data width for the packet store.
package ulss_pck_store_pkg;
    localparam int DATA_W = 64;
    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } pck_word_t;
    typedef enum logic {WR_IDLE, WR_PKT} wr_state_e;
    typedef enum logic {RD_IDLE, RD_SEND} rd_state_e;
endpackage

// File: rtl/ulss_sync_fifo.sv
// ulss_sync_fifo: single-clock FIFO of packet words with registered full/empty.
module ulss_sync_fifo
    import ulss_pck_store_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  pck_word_t       i_data,
    output pck_word_t       o_data,
    output logic            o_full,
    output logic            o_empty,
    output logic [ADDR_W:0] o_level
);
    pck_word_t       r_mem [DEPTH];
    logic [ADDR_W:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0] w_wr_nxt, w_rd_nxt;
    logic            r_full, r_empty;
    logic            w_push, w_pop;
    assign w_push   = i_push && !r_full;
    assign w_pop    = i_pop && !r_empty;
    assign w_wr_nxt = r_wr_ptr + {{ADDR_W{1'b0}}, w_push};
    assign w_rd_nxt = r_rd_ptr + {{ADDR_W{1'b0}}, w_pop};
    assign o_data   = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign o_full   = r_full;
    assign o_empty  = r_empty;
    assign o_level  = r_wr_ptr - r_rd_ptr;
    // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_full   <= (w_wr_nxt[ADDR_W] != w_rd_nxt[ADDR_W]) &&
                        (w_wr_nxt[ADDR_W-1:0] == w_rd_nxt[ADDR_W-1:0]);
            r_empty  <= (w_wr_nxt == w_rd_nxt);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
    end
endmodule

// File: rtl/ulss_pck_store.sv
// ulss_pck_store: buffers framed packets and streams one whole packet per scheduler grant.
module ulss_pck_store
    import ulss_pck_store_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              ulss_pck_store_clk,
    input  logic              ulss_pck_store_rst,
    input  logic              ulss_pck_store_sw_rst,
    input  logic              wr_valid,
    input  logic              wr_sop,
    input  logic              wr_eop,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_err,
    input  logic              pck_rd_en_grnt,
    output logic              pck_str_empty,
    output logic              pck_str_sop,
    output logic [DATA_W-1:0] pck_str_data,
    output logic              pck_str_eop,
    output logic              pck_str_vld,
    output logic              rd_err,
    output logic [ADDR_W:0]   fill_lvl
);
    wr_state_e         r_wr_st;
    rd_state_e         r_rd_st;
    logic [ADDR_W:0]   r_pkt_cnt, w_cnt_nxt;
    logic              r_empty, r_wr_err, r_rd_err, r_sop, r_eop, r_vld;
    logic [DATA_W-1:0] r_data;
    logic              w_rst, w_full, w_fifo_empty, w_acc, w_push, w_eop_wr, w_grant_ok, w_pop;
    pck_word_t         w_head, w_in;
    assign w_rst      = ulss_pck_store_rst || ulss_pck_store_sw_rst;
    assign w_acc      = wr_valid && wr_ready;
    assign w_push     = w_acc && ((r_wr_st == WR_IDLE) ? wr_sop : !wr_sop);
    assign w_eop_wr   = w_push && wr_eop;
    assign w_grant_ok = pck_rd_en_grnt && (r_rd_st == RD_IDLE) && !r_empty;
    // Packet is fully stored before its grant, so the next word is always present.
    assign w_pop      = w_grant_ok || ((r_rd_st == RD_SEND) && !r_eop);
    assign w_cnt_nxt  = r_pkt_cnt + {{ADDR_W{1'b0}}, w_eop_wr} - {{ADDR_W{1'b0}}, w_grant_ok};
    assign w_in       = '{sop: wr_sop, eop: wr_eop, data: wr_data};
    assign wr_ready      = !w_full;
    assign wr_err        = r_wr_err;
    assign rd_err        = r_rd_err;
    assign pck_str_empty = r_empty;
    assign pck_str_sop   = r_sop;
    assign pck_str_eop   = r_eop;
    assign pck_str_vld   = r_vld;
    assign pck_str_data  = r_data;
    ulss_sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
        .clk     (ulss_pck_store_clk),
        .rst     (w_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_in),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_fifo_empty),
        .o_level (fill_lvl)
    );
    always_ff @(posedge ulss_pck_store_clk) begin
        if (w_rst) begin
            r_wr_st  <= WR_IDLE;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_acc && !w_push;
            if (w_push) r_wr_st <= wr_eop ? WR_IDLE : WR_PKT;
        end
    end
    always_ff @(posedge ulss_pck_store_clk) begin
        if (w_rst) begin
            r_rd_st   <= RD_IDLE;
            r_pkt_cnt <= '0;
            r_empty   <= 1'b1;
            r_rd_err  <= 1'b0;
            r_vld     <= 1'b0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_data    <= '0;
        end else begin
            r_pkt_cnt <= w_cnt_nxt;
            r_empty   <= (w_cnt_nxt == '0);
            r_rd_err  <= pck_rd_en_grnt && !w_grant_ok;
            if (w_pop && !w_fifo_empty) begin
                r_rd_st <= RD_SEND;
                r_vld   <= 1'b1;
                r_sop   <= w_head.sop;
                r_eop   <= w_head.eop;
                r_data  <= w_head.data;
            end else if (r_rd_st == RD_SEND) begin
                r_rd_st <= RD_IDLE;
                r_vld   <= 1'b0;
                r_sop   <= 1'b0;
                r_eop   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ulss_pck_store.sv
// tb_ulss_pck_store: table vectors, corner sequences and random traffic against a queue model.
module tb_ulss_pck_store;
    logic        clk = 0, rst = 1, sw_rst = 0;
    logic        wr_valid = 0, wr_sop = 0, wr_eop = 0, grant = 0;
    logic [63:0] wr_data = '0;
    logic        wr_ready, wr_err, str_empty, str_sop, str_eop, str_vld, rd_err;
    logic [63:0] str_data;
    logic [6:0]  fill_lvl;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    ulss_pck_store dut (
        .ulss_pck_store_clk    (clk),
        .ulss_pck_store_rst    (rst),
        .ulss_pck_store_sw_rst (sw_rst),
        .wr_valid              (wr_valid),
        .wr_sop                (wr_sop),
        .wr_eop                (wr_eop),
        .wr_data               (wr_data),
        .wr_ready              (wr_ready),
        .wr_err                (wr_err),
        .pck_rd_en_grnt        (grant),
        .pck_str_empty         (str_empty),
        .pck_str_sop           (str_sop),
        .pck_str_data          (str_data),
        .pck_str_eop           (str_eop),
        .pck_str_vld           (str_vld),
        .rd_err                (rd_err),
        .fill_lvl              (fill_lvl)
    );

    // Reference: stored-but-unsent words, words of the granted packet still to appear, packet count.
    typedef struct packed { logic sop; logic eop; logic [63:0] data; } w_t;
    w_t          mq[$];
    w_t          ms[$];
    int          mpc;
    bit          min_pkt, m_vld, m_sop, m_eop, m_werr, m_rerr;
    logic [63:0] m_data;

    function automatic int m_fill();
        return mq.size() + ms.size();
    endfunction

    function automatic void model_reset();
        mq.delete(); ms.delete();
        mpc = 0; min_pkt = 0;
        m_vld = 0; m_sop = 0; m_eop = 0; m_werr = 0; m_rerr = 0; m_data = '0;
    endfunction

    function automatic void model_step();
        bit acc, gok;
        w_t w;
        if (rst || sw_rst) begin
            model_reset();
            return;
        end
        acc = wr_valid && (m_fill() < 64);
        gok = grant && !m_vld && (mpc > 0);
        m_rerr = grant && !gok;
        m_werr = 0;
        if (gok) begin
            do begin
                w = mq.pop_front();
                ms.push_back(w);
            end while (!w.eop && mq.size() > 0);
            mpc--;
        end
        if (acc) begin
            if (wr_sop == !min_pkt) begin
                mq.push_back('{sop: wr_sop, eop: wr_eop, data: wr_data});
                if (wr_eop) mpc++;
                min_pkt = !wr_eop;
            end else m_werr = 1;
        end
        if (ms.size() > 0) begin
            w = ms.pop_front();
            m_vld = 1; m_sop = w.sop; m_eop = w.eop; m_data = w.data;
        end else begin
            m_vld = 0; m_sop = 0; m_eop = 0;
        end
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", n, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("wr_ready", 64'(wr_ready), 64'(m_fill() < 64));
        chk("wr_err", 64'(wr_err), 64'(m_werr));
        chk("rd_err", 64'(rd_err), 64'(m_rerr));
        chk("empty", 64'(str_empty), 64'(mpc == 0));
        chk("vld", 64'(str_vld), 64'(m_vld));
        chk("sop", 64'(str_sop), 64'(m_sop));
        chk("eop", 64'(str_eop), 64'(m_eop));
        chk("data", str_data, m_data);
        chk("fill", 64'(fill_lvl), 64'(m_fill()));
    endtask

    task automatic wr(input logic s, input logic e, input logic [63:0] d, input logic g);
        wr_valid = 1; wr_sop = s; wr_eop = e; wr_data = d; grant = g;
        cyc();
        wr_valid = 0; wr_sop = 0; wr_eop = 0; grant = 0;
    endtask

    task automatic drain();
        int n = 0;
        wr_valid = 0;
        while ((mpc > 0 || m_vld) && n < 3000) begin
            grant = (mpc > 0) && !m_vld;
            cyc();
            n++;
        end
        grant = 0;
        chk("drain_bound", 64'(mpc > 0 || m_vld), 64'(0));
    endtask

    typedef struct {
        logic v, s, e; logic [63:0] d; logic g;
        logic x_vld, x_sop, x_eop; logic [63:0] x_data; logic x_empty, x_werr, x_rerr; int x_fill;
    } vec_t;
    vec_t tbl[19];

    initial begin
        int pidx = 0, plen = 1;
        bit took;
        tbl[0]  = '{1,1,0,64'hA0,0, 0,0,0,64'h0, 1,0,0,1};
        tbl[1]  = '{1,0,0,64'hA1,0, 0,0,0,64'h0, 1,0,0,2};
        tbl[2]  = '{1,0,0,64'hA2,0, 0,0,0,64'h0, 1,0,0,3};
        tbl[3]  = '{1,0,1,64'hA3,0, 0,0,0,64'h0, 0,0,0,4};
        tbl[4]  = '{0,0,0,64'h0,1,  1,1,0,64'hA0, 1,0,0,3};
        tbl[5]  = '{0,0,0,64'h0,0,  1,0,0,64'hA1, 1,0,0,2};
        tbl[6]  = '{0,0,0,64'h0,0,  1,0,0,64'hA2, 1,0,0,1};
        tbl[7]  = '{0,0,0,64'h0,0,  1,0,1,64'hA3, 1,0,0,0};
        tbl[8]  = '{0,0,0,64'h0,0,  0,0,0,64'hA3, 1,0,0,0};
        tbl[9]  = '{1,1,1,64'h55,0, 0,0,0,64'hA3, 0,0,0,1};
        tbl[10] = '{0,0,0,64'h0,1,  1,1,1,64'h55, 1,0,0,0};
        tbl[11] = '{0,0,0,64'h0,1,  0,0,0,64'h55, 1,0,1,0};
        tbl[12] = '{1,0,0,64'h11,0, 0,0,0,64'h55, 1,1,0,0};
        tbl[13] = '{1,1,0,64'hB0,0, 0,0,0,64'h55, 1,0,0,1};
        tbl[14] = '{1,1,0,64'hBB,0, 0,0,0,64'h55, 1,1,0,1};
        tbl[15] = '{1,0,1,64'hB1,0, 0,0,0,64'h55, 0,0,0,2};
        tbl[16] = '{0,0,0,64'h0,1,  1,1,0,64'hB0, 1,0,0,1};
        tbl[17] = '{0,0,0,64'h0,0,  1,0,1,64'hB1, 1,0,0,0};
        tbl[18] = '{0,0,0,64'h0,0,  0,0,0,64'hB1, 1,0,0,0};
        model_reset();
        cyc();
        cyc();
        rst = 0;
        #1;
        chk("rst_ready", 64'(wr_ready), 64'(1));
        chk("rst_empty", 64'(str_empty), 64'(1));
        chk("rst_vld", 64'(str_vld), 64'(0));
        chk("rst_fill", 64'(fill_lvl), 64'(0));

        for (int i = 0; i < 19; i++) begin
            wr_valid = tbl[i].v; wr_sop = tbl[i].s; wr_eop = tbl[i].e; wr_data = tbl[i].d; grant = tbl[i].g;
            cyc();
            chk($sformatf("tbl%0d_vld", i), 64'(str_vld), 64'(tbl[i].x_vld));
            chk($sformatf("tbl%0d_sop", i), 64'(str_sop), 64'(tbl[i].x_sop));
            chk($sformatf("tbl%0d_eop", i), 64'(str_eop), 64'(tbl[i].x_eop));
            chk($sformatf("tbl%0d_data", i), str_data, tbl[i].x_data);
            chk($sformatf("tbl%0d_empty", i), 64'(str_empty), 64'(tbl[i].x_empty));
            chk($sformatf("tbl%0d_werr", i), 64'(wr_err), 64'(tbl[i].x_werr));
            chk($sformatf("tbl%0d_rerr", i), 64'(rd_err), 64'(tbl[i].x_rerr));
            chk($sformatf("tbl%0d_fill", i), 64'(fill_lvl), 64'(tbl[i].x_fill));
        end
        wr_valid = 0; grant = 0;

        // Fill the store completely, then a held word goes in right after the first read.
        for (int p = 0; p < 8; p++)
            for (int w = 0; w < 8; w++)
                wr(w == 0, w == 7, {$urandom, $urandom}, 0);
        chk("full_ready", 64'(wr_ready), 64'(0));
        chk("full_fill", 64'(fill_lvl), 64'(64));
        wr_valid = 1; wr_sop = 1; wr_eop = 1; wr_data = 64'hCC; grant = 1;
        cyc();
        grant = 0;
        chk("full_ready_after_grant", 64'(wr_ready), 64'(1));
        cyc();
        wr_valid = 0; wr_sop = 0; wr_eop = 0;
        chk("full_held_fill", 64'(fill_lvl), 64'(63));
        drain();

        // Eop write and grant acceptance together keep the packet count.
        wr(1, 0, 64'h10, 0);
        wr(0, 1, 64'h11, 0);
        wr(1, 0, 64'h20, 0);
        wr(0, 1, 64'h21, 1);
        chk("eop_grant_empty", 64'(str_empty), 64'(0));
        drain();

        // Soft flush while the third word of a packet is on the output.
        for (int w = 0; w < 5; w++) wr(w == 0, w == 4, 64'h30 + 64'(w), 0);
        wr(1, 1, 64'h40, 0);
        grant = 1; cyc(); grant = 0;
        cyc();
        cyc();
        chk("swr_third_word", str_data, 64'h32);
        sw_rst = 1; cyc(); sw_rst = 0;
        chk("swr_vld", 64'(str_vld), 64'(0));
        chk("swr_empty", 64'(str_empty), 64'(1));
        chk("swr_fill", 64'(fill_lvl), 64'(0));
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("swr_no_eop", 64'(str_eop), 64'(0));
        end

        // Random traffic: framed packets of 1..8 words, malformed words, random grants and flushes.
        wr_valid = 0;
        for (int c = 0; c < 4000; c++) begin
            took = wr_valid && (m_fill() < 64);
            if (took || !wr_valid) begin
                if ($urandom_range(0, 3) == 0) wr_valid = 0;
                else begin
                    wr_valid = 1;
                    wr_data = {$urandom, $urandom};
                    if ($urandom_range(0, 19) == 0) begin
                        wr_sop = (pidx != 0);
                        wr_eop = 1'($urandom);
                    end else begin
                        if (pidx == 0) plen = $urandom_range(1, 8);
                        wr_sop = (pidx == 0);
                        wr_eop = (pidx == plen - 1);
                        pidx = wr_eop ? 0 : pidx + 1;
                    end
                end
            end
            grant = ($urandom_range(0, 4) == 0);
            sw_rst = 0;
            if ($urandom_range(0, 799) == 0) begin
                sw_rst = 1;
                wr_valid = 0;
                pidx = 0;
            end
            cyc();
        end
        sw_rst = 0;
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
